// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DMEM_BASE_ADDR_DEFAULT = 32'h1001_0000;
  localparam int          DMEM_CNT_W             = 4;

  // Offset compare keeps a wrap below base from aliasing into the window.
  function automatic logic addr_error(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] span);
    logic [31:0] off_s;
    off_s = addr - base;
    return (addr[1:0] != 2'b00) || (addr < base) || (off_s >= span);
  endfunction

endpackage

// File: rtl/dmem_word_array.sv
// Word storage with per-byte-lane synchronous write and registered read.
module dmem_word_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [3:0]       wr_be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wr_data,
  input  logic             rd_en,
  output logic [31:0]      rd_data
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rd_data_r;

  // Lane-masked write and read-data capture; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem_r[idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rd_data_r <= mem_r[idx];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/data_memory_responder.sv
// Single-outstanding load/store responder with WAIT_CYCLES of latency.
// Optional byte-lane stores are enabled by defining DMEM_BYTE_STROBE_EN.
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR_DEFAULT,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  req_be,
`endif
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int                    IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0]           SPAN_BYTES = 32'(DEPTH_WORDS) << 2;
  localparam int                    WAIT_INT   = WAIT_CYCLES;
  localparam logic [DMEM_CNT_W-1:0] WAIT_LD    = WAIT_INT[DMEM_CNT_W-1:0];

  state_t                state_r;
  state_t                state_s;
  logic [DMEM_CNT_W-1:0] cnt_r;
  logic                  lat_write_r;
  logic [31:0]           lat_addr_r;
  logic [31:0]           lat_wdata_r;
  logic [3:0]            lat_be_r;
  logic                  resp_error_r;
  logic                  load_sel_r;

  logic                  accept_s;
  logic                  enter_resp_s;
  logic                  commit_s;
  logic [3:0]            be_in_s;
  logic                  op_write_s;
  logic [31:0]           op_addr_s;
  logic [31:0]           op_wdata_s;
  logic [3:0]            op_be_s;
  logic                  op_err_s;
  logic [IDX_W-1:0]      op_idx_s;
  logic [31:0]           arr_rdata_s;

`ifdef DMEM_BYTE_STROBE_EN
  assign be_in_s = req_be;
`else
  assign be_in_s = 4'hF;
`endif

  assign req_ready = (state_r == IDLE) && !reset;
  assign accept_s  = req_valid && req_ready;

  // With zero wait states the request commits on its own acceptance edge,
  // so the operation is taken straight from the port while idle.
  always_comb begin
    op_write_s = lat_write_r;
    op_addr_s  = lat_addr_r;
    op_wdata_s = lat_wdata_r;
    op_be_s    = lat_be_r;
    if (state_r == IDLE) begin
      op_write_s = req_write;
      op_addr_s  = req_addr;
      op_wdata_s = req_wdata;
      op_be_s    = be_in_s;
    end else begin
      op_write_s = lat_write_r;
      op_addr_s  = lat_addr_r;
      op_wdata_s = lat_wdata_r;
      op_be_s    = lat_be_r;
    end
  end

  assign op_err_s = addr_error(op_addr_s, BASE_ADDR, SPAN_BYTES);
  assign op_idx_s = IDX_W'((op_addr_s - BASE_ADDR) >> 2);

  // Next-state decode and detection of the RESP entry edge.
  always_comb begin
    state_s      = state_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (WAIT_CYCLES == 0) begin
            state_s      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_s      = WAIT;
            enter_resp_s = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd1) begin
          state_s      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          state_s      = WAIT;
          enter_resp_s = 1'b0;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign commit_s = enter_resp_s && !op_err_s && !reset;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latch, wait counter and held response status.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r        <= 4'd0;
      lat_write_r  <= 1'b0;
      lat_addr_r   <= 32'h0;
      lat_wdata_r  <= 32'h0;
      lat_be_r     <= 4'h0;
      resp_error_r <= 1'b0;
      load_sel_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        lat_write_r <= req_write;
        lat_addr_r  <= req_addr;
        lat_wdata_r <= req_wdata;
        lat_be_r    <= be_in_s;
        cnt_r       <= WAIT_LD;
      end else if (state_r == WAIT) begin
        cnt_r <= cnt_r - 4'd1;
      end
      if (enter_resp_s) begin
        resp_error_r <= op_err_s;
        load_sel_r   <= !op_write_s && !op_err_s;
      end
    end
  end

  dmem_word_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .wr_en  (commit_s && op_write_s),
    .wr_be  (op_be_s),
    .idx    (op_idx_s),
    .wr_data(op_wdata_s),
    .rd_en  (commit_s && !op_write_s),
    .rd_data(arr_rdata_s)
  );

  // Array read data only moves on a load commit, so gating it holds the value.
  assign resp_valid = (state_r == RESP);
  assign resp_error = resp_error_r;
  assign resp_rdata = load_sel_r ? arr_rdata_s : 32'h0;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized self-checking bench for data_memory_responder (WAIT 2 and WAIT 0 instances).
module tb_data_memory_responder;

  localparam logic [31:0] BASE  = 32'h1001_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
  logic        req_ready, resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        valid_b = 1'b0, write_b = 1'b0;
  logic [31:0] addr_b = 32'h0, wdata_b = 32'h0;
  logic        ready_b, rvalid_b, rerror_b;
  logic [31:0] rdata_b;
  logic [3:0]  cur_be = 4'hF;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  req_be = 4'hF;
  logic [3:0]  be_b = 4'hF;
`endif

  int checks = 0;
  int fails  = 0;
  logic [31:0] model [int];

  always #5 clk = ~clk;

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(req_be),
`endif
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error));

  data_memory_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid_b), .req_write(write_b),
    .req_addr(addr_b), .req_wdata(wdata_b),
`ifdef DMEM_BYTE_STROBE_EN
    .req_be(be_b),
`endif
    .req_ready(ready_b), .resp_valid(rvalid_b), .resp_rdata(rdata_b),
    .resp_error(rerror_b));

  // Reference: error iff misaligned or outside [BASE, BASE+4*DEPTH) in 64-bit math.
  function automatic logic exp_err(input logic [31:0] a);
    logic [63:0] a64;
    a64 = {32'h0, a};
    return (a[1:0] != 2'b00) || (a64 < {32'h0, BASE}) ||
           (a64 >= {32'h0, BASE} + 64'(DEPTH) * 64'd4);
  endfunction

  function automatic void model_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] be, output logic [31:0] rd, output logic er);
    int idx;
    logic [31:0] word;
    er = exp_err(a);
    rd = 32'h0;
    if (!er) begin
      idx  = int'((a - BASE) / 32'd4);
      word = model.exists(idx) ? model[idx] : 32'h0;
      if (w) begin
        for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = d[8*i +: 8];
        model[idx] = word;
      end else begin
        rd = word;
      end
    end
  endfunction

  // One request on the WAIT_CYCLES=2 instance; watch 8 cycles after acceptance.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      output int lat, output int npulse, output logic [31:0] rd, output logic er);
    logic acc;
    acc = 1'b0; lat = -1; npulse = 0; rd = 32'h0; er = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
    req_be = cur_be;
`endif
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (acc) begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (resp_valid) begin
          npulse++;
          if (lat < 0) begin lat = k; rd = resp_rdata; er = resp_error; end
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", req_ready); end
    if (resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", resp_valid); end
    if (resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", resp_rdata); end
    if (resp_error !== 1'b0) begin fails++; $display("FAIL reset_error: got %b expected 0", resp_error); end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks += 2;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b expected 1", req_ready); end
    if (ready_b !== 1'b1) begin fails++; $display("FAIL post_reset_ready_b: got %b expected 1", ready_b); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, np; logic [31:0] rd, erd; logic er, eer;
    cur_be = 4'hF;
    model_op(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, 4'hF, erd, eer);
    xact(1'b1, 32'h1001_0004, 32'hDEAD_BEEF, lat, np, rd, er);
    checks += 3;
    if (lat !== 3 || np !== 1) begin fails++; $display("FAIL basic_store_latency: got lat %0d pulses %0d expected 3/1", lat, np); end
    if (rd !== 32'h0) begin fails++; $display("FAIL basic_store_rdata: got %h expected 0", rd); end
    if (er !== 1'b0) begin fails++; $display("FAIL basic_store_error: got %b expected 0", er); end
    xact(1'b0, 32'h1001_0004, 32'h0, lat, np, rd, er);
    checks += 4;
    if (lat !== 3 || np !== 1) begin fails++; $display("FAIL basic_load_latency: got lat %0d pulses %0d expected 3/1", lat, np); end
    if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_load_rdata: got %h expected deadbeef", rd); end
    if (er !== 1'b0) begin fails++; $display("FAIL basic_load_error: got %b expected 0", er); end
    @(negedge clk);
    if (resp_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_rdata_hold: got %h expected deadbeef", resp_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_errors;
    int lat, np; logic [31:0] rd, erd; logic er, eer;
    logic [31:0] addrs [3];
    logic        wr [3];
    addrs[0] = 32'h1001_0002; addrs[1] = 32'h0FFF_FFFC; addrs[2] = 32'h1001_1000;
    wr[0] = 1'b0; wr[1] = 1'b0; wr[2] = 1'b1;
    cur_be = 4'hF;
    model_op(1'b1, 32'h1001_0FFC, 32'h5A5A_1234, 4'hF, erd, eer);
    xact(1'b1, 32'h1001_0FFC, 32'h5A5A_1234, lat, np, rd, er);
    for (int i = 0; i < 3; i++) begin
      xact(wr[i], addrs[i], 32'hFFFF_FFFF, lat, np, rd, er);
      checks += 2;
      if (lat !== 3 || np !== 1) begin fails++; $display("FAIL err_latency[%0d]: got lat %0d pulses %0d expected 3/1", i, lat, np); end
      if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL err_resp[%0d]: got err %b rdata %h expected 1/0", i, er, rd); end
    end
    @(negedge clk);
    checks += 2;
    if (resp_error !== 1'b1) begin fails++; $display("FAIL err_hold: got %b expected 1", resp_error); end
    @(posedge clk); #1;
    xact(1'b0, 32'h1001_0FFC, 32'h0, lat, np, rd, er);
    if (rd !== 32'h5A5A_1234 || er !== 1'b0) begin fails++; $display("FAIL err_last_word: got %h/%b expected 5a5a1234/0", rd, er); end
  endtask

  task automatic test_random;
    int lat, np, kind, j; logic [31:0] rd, erd, a, d; logic er, eer, w;
    int pool [16];
    for (int i = 0; i < 16; i++) pool[i] = (i == 0) ? 0 : (i == 15) ? DEPTH - 1 : int'($urandom_range(1, DEPTH - 2));
    cur_be = 4'hF;
    for (int i = 0; i < 16; i++) begin
      a = BASE + 32'(pool[i]) * 32'd4; d = $urandom;
      model_op(1'b1, a, d, 4'hF, erd, eer);
      xact(1'b1, a, d, lat, np, rd, er);
    end
    for (int n = 0; n < 40; n++) begin
      kind = int'($urandom_range(0, 8)); j = int'($urandom_range(0, 15));
      w = 1'(($urandom_range(0, 1))); d = $urandom;
      case (kind)
        6:       a = BASE + 32'(pool[j]) * 32'd4 + 32'($urandom_range(1, 3));
        7:       a = BASE - 32'd4 * 32'($urandom_range(1, 100000));
        8:       a = BASE + 32'h1000 + 32'd4 * 32'($urandom_range(0, 1 << 20));
        default: a = BASE + 32'(pool[j]) * 32'd4;
      endcase
`ifdef DMEM_BYTE_STROBE_EN
      cur_be = 4'($urandom_range(0, 15));
`endif
      model_op(w, a, d, cur_be, erd, eer);
      xact(w, a, d, lat, np, rd, er);
      checks += 2;
      if (lat !== 3 || np !== 1) begin fails++; $display("FAIL rand_latency[%0d]: got lat %0d pulses %0d expected 3/1", n, lat, np); end
      if (rd !== erd || er !== eer) begin fails++; $display("FAIL rand_resp[%0d] addr %h w %b: got %h/%b expected %h/%b", n, a, w, rd, er, erd, eer); end
    end
    cur_be = 4'hF;
  endtask

  task automatic test_reset_mid;
    int lat, np; logic [31:0] rd, erd; logic er, eer;
    cur_be = 4'hF;
    model_op(1'b1, 32'h1001_0010, 32'h0BAD_F00D, 4'hF, erd, eer);
    xact(1'b1, 32'h1001_0010, 32'h0BAD_F00D, lat, np, rd, er);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h1001_0010; req_wdata = 32'h7777_7777;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    np = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); if (resp_valid) np++;
      @(posedge clk); #1;
    end
    checks += 2;
    if (np !== 0) begin fails++; $display("FAIL midreset_no_resp: got %0d pulses expected 0", np); end
    xact(1'b0, 32'h1001_0010, 32'h0, lat, np, rd, er);
    if (rd !== 32'h0BAD_F00D) begin fails++; $display("FAIL midreset_store_dropped: got %h expected 0badf00d", rd); end
  endtask

  task automatic test_ignore_in_wait;
    int lat, np; logic [31:0] rd, erd; logic er, eer;
    cur_be = 4'hF;
    model_op(1'b1, 32'h1001_0020, 32'h1357_9BDF, 4'hF, erd, eer);
    xact(1'b1, 32'h1001_0020, 32'h1357_9BDF, lat, np, rd, er);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1001_0020;
    @(posedge clk); #1;
    req_write = 1'b1; req_wdata = 32'hFFFF_FFFF;
    np = 0; lat = -1; rd = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valid) begin np++; lat = k; rd = resp_rdata; end
      @(posedge clk); #1;
      if (k == 1) req_valid = 1'b0;
    end
    checks += 3;
    if (np !== 1 || lat !== 3) begin fails++; $display("FAIL ignore_wait_pulses: got %0d pulses lat %0d expected 1/3", np, lat); end
    if (rd !== 32'h1357_9BDF) begin fails++; $display("FAIL ignore_wait_rdata: got %h expected 13579bdf", rd); end
    xact(1'b0, 32'h1001_0020, 32'h0, lat, np, rd, er);
    if (rd !== 32'h1357_9BDF) begin fails++; $display("FAIL ignore_wait_unchanged: got %h expected 13579bdf", rd); end
  endtask

  task automatic test_back_to_back;
    logic odd;
    valid_b = 1'b1; write_b = 1'b1; addr_b = BASE + 32'd8; wdata_b = 32'h2468_ACE0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); @(negedge clk);
      odd = (k % 2) == 1;
      checks += 2;
      if (rvalid_b !== odd) begin fails++; $display("FAIL b2b_valid[%0d]: got %b expected %b", k, rvalid_b, odd); end
      if (ready_b !== !odd) begin fails++; $display("FAIL b2b_ready[%0d]: got %b expected %b", k, ready_b, !odd); end
    end
    valid_b = 1'b0;
    @(posedge clk); @(negedge clk);
    valid_b = 1'b1; write_b = 1'b0;
    @(posedge clk); @(negedge clk);
    valid_b = 1'b0;
    checks += 1;
    if (rvalid_b !== 1'b1 || rdata_b !== 32'h2468_ACE0 || rerror_b !== 1'b0) begin
      fails++; $display("FAIL b2b_load: got v%b %h e%b expected 1 2468ace0 0", rvalid_b, rdata_b, rerror_b);
    end
    @(posedge clk); #1;
  endtask

`ifdef DMEM_BYTE_STROBE_EN
  task automatic test_byte_strobe;
    int lat, np; logic [31:0] rd, erd; logic er, eer;
    cur_be = 4'hF;  model_op(1'b1, 32'h1001_0030, 32'h1122_3344, cur_be, erd, eer);
    xact(1'b1, 32'h1001_0030, 32'h1122_3344, lat, np, rd, er);
    cur_be = 4'b0101; model_op(1'b1, 32'h1001_0030, 32'hAABB_CCDD, cur_be, erd, eer);
    xact(1'b1, 32'h1001_0030, 32'hAABB_CCDD, lat, np, rd, er);
    cur_be = 4'hF;
    xact(1'b0, 32'h1001_0030, 32'h0, lat, np, rd, er);
    checks += 3;
    if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL strobe_merge: got %h expected 11bb33dd", rd); end
    cur_be = 4'h0;
    xact(1'b1, 32'h1001_0030, 32'hFFFF_FFFF, lat, np, rd, er);
    if (np !== 1 || er !== 1'b0) begin fails++; $display("FAIL strobe_zero_resp: got %0d pulses err %b expected 1/0", np, er); end
    cur_be = 4'hF;
    xact(1'b0, 32'h1001_0030, 32'h0, lat, np, rd, er);
    if (rd !== 32'h11BB_33DD) begin fails++; $display("FAIL strobe_zero_unchanged: got %h expected 11bb33dd", rd); end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_ignore_in_wait();
`ifdef DMEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
